umult_sched: RTL and testbench
==============================

// Module: umult_sched
// PURPOSE
//  Shares one pipelined 32x32 unsigned multiplier among NREQ requesters.
//  Round-robin arbitration grants at most one operand pair per cycle and drives it into the multiplier.
//  A LATENCY-deep tag pipeline steers each 64-bit product back to its requester.
//  Sits between the integer pipes and the multiplier datapath.
// PARAMETERS
//  NREQ     2   number of requesters (2..4)
//  LATENCY  4   cycles from mult_start high to mult_out valid (>=1)
//  WIDTH    32  operand width; product is 2*WIDTH
// PORTS
//  clk          in   1             rising-edge clock
//  rst_n        in   1             asynchronous active-low reset
//  req_valid    in   NREQ          requester i has an operand pair
//  req_in1      in   NREQ*WIDTH    operand A, slice i = [i*WIDTH +: WIDTH]
//  req_in2      in   NREQ*WIDTH    operand B, same slicing
//  req_ready    out  NREQ          one-hot grant; transfer = valid & ready
//  flush        in   1             synchronous kill of all in-flight ops
//  mult_start   out  1             issue strobe to multiplier
//  mult_in1     out  WIDTH         registered operand A
//  mult_in2     out  WIDTH         registered operand B
//  mult_out     in   2*WIDTH       multiplier product
//  resp_valid   out  NREQ          one-hot; product for requester i valid this cycle
//  resp_data    out  2*WIDTH       product, registered
//  busy         out  1             any op in flight or state != RUN
// BEHAVIOUR
//  Reset: all outputs 0, rr pointer = 0, tag pipe empty, state = RUN.
//  FSM states:
//   RUN:    arbitrate and issue.
//   FLUSH:  no grants; counts down LATENCY cycles, then returns to RUN.
//  Transitions:
//   RUN -> FLUSH when flush = 1.
//   FLUSH stays in FLUSH and reloads the counter when flush = 1 again.
//  Arbitration (RUN only): search starts at the rr pointer and grants the first i with req_valid[i].
//  req_ready is combinational from req_valid, the pointer and the state.
//  After a grant to i, the pointer becomes (i+1) mod NREQ; with no grant the pointer holds.
//  Issue: on transfer, the next edge registers mult_in1/mult_in2 and pulses mult_start for 1 cycle.
//  Tag pipe: a {valid, id} shift register, LATENCY deep, shifts every cycle.
//  Response: when the tag reaches the end of the pipe, the next edge registers resp_data <= mult_out and raises resp_valid[id] for 1 cycle.
//  Latency: transfer edge T -> resp_valid high in cycle T+LATENCY+1.
//  Throughput: 1 op per cycle, no back-pressure. Requesters must accept resp_valid in the cycle it is high.
//  flush:
//   - clears every tag-pipe valid at the next edge, so in-flight results are never reported;
//   - suppresses any grant in the same cycle;
//   - holds mult_start at 0 during FLUSH so the multiplier pipe drains.
//  Simultaneous flush and req_valid: flush wins, req_ready = 0.
//  Reset asserted mid-operation: tags and outputs clear immediately (async); no response is produced.
//  mult_in1/mult_in2 hold their last value when mult_start = 0.
//  resp_data holds its last value when resp_valid = 0.
// CONFIGURATION
//  UMULT_SCHED_PERF_EN defined: adds outputs
//   perf_issued  out 32  issued-op count
//   perf_stall   out 32  cycles with req_valid != 0 and no grant
//  Both counters reset to 0 and wrap modulo 2^32.
//  UMULT_SCHED_PERF_EN undefined: these ports and the counters do not exist; behaviour is otherwise identical.
// TESTING
//  1. Single op: req0 in1 = 3, in2 = 5 at T -> resp_valid = 2'b01, resp_data = 15 at T+5.
//  2. Both valid every cycle, 6 cycles -> grants alternate 0,1,0,1,0,1. Responses follow in order, each with the correct id.
//  3. Max operands 0xFFFFFFFF x 0xFFFFFFFF -> resp_data = 64'hFFFFFFFE00000001.
//  4. flush 2 cycles after issuing 2 ops:
//     - no resp_valid for either op;
//     - req_ready = 0 for LATENCY cycles, then issue resumes.
//  5. rst_n low while 3 ops are in flight -> outputs 0 at once, no responses afterwards, pointer = 0.
//  6. PERF_EN, req1 held for 10 cycles while req0 is also held -> perf_issued = 10, perf_stall = 0.

Source files
------------

// File: rtl/umult_sched.sv
// -----------------------------------------------------------------------------
// umult_sched
//   Shares one pipelined unsigned WIDTHxWIDTH multiplier among NREQ requesters.
//   A round-robin arbiter grants at most one operand pair per cycle. The
//   granted pair is registered onto mult_in1/mult_in2 with a one-cycle
//   mult_start strobe. A LATENCY-deep {valid, id} tag pipe follows the
//   operation through the multiplier and steers the product back to its
//   requester as a registered one-hot resp_valid plus resp_data.
//
//   Optional feature: define UMULT_SCHED_PERF_EN to add the free-running
//   perf_issued / perf_stall counters (ports exist only when defined).
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   req_valid   [NREQ]         requester i has an operand pair
//   req_in1     [NREQ*WIDTH]   operand A, slice i = [i*WIDTH +: WIDTH]
//   req_in2     [NREQ*WIDTH]   operand B, same slicing
//   req_ready   [NREQ]         one-hot grant (combinational); transfer = valid & ready
//   flush                      kill every in-flight op, then drain for LATENCY cycles
//   mult_start                 issue strobe to the multiplier
//   mult_in1/2  [WIDTH]        registered operands (hold while mult_start = 0)
//   mult_out    [2*WIDTH]      multiplier product, valid LATENCY cycles after transfer
//   resp_valid  [NREQ]         one-hot, product for requester i this cycle
//   resp_data   [2*WIDTH]      registered product (holds while resp_valid = 0)
//   busy                       any op in flight or draining after a flush
//   perf_issued [32]           (UMULT_SCHED_PERF_EN) issued-op count
//   perf_stall  [32]           (UMULT_SCHED_PERF_EN) cycles with requests but no grant
// -----------------------------------------------------------------------------
module umult_sched #(
    parameter int NREQ    = 2,
    parameter int LATENCY = 4,
    parameter int WIDTH   = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WIDTH-1:0]   req_in1,
    input  logic [NREQ*WIDTH-1:0]   req_in2,
    output logic [NREQ-1:0]         req_ready,
    input  logic                    flush,
    output logic                    mult_start,
    output logic [WIDTH-1:0]        mult_in1,
    output logic [WIDTH-1:0]        mult_in2,
    input  logic [2*WIDTH-1:0]      mult_out,
    output logic [NREQ-1:0]         resp_valid,
    output logic [2*WIDTH-1:0]      resp_data,
    output logic                    busy
`ifdef UMULT_SCHED_PERF_EN
    ,
    output logic [31:0]             perf_issued,
    output logic [31:0]             perf_stall
`endif
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = $clog2(LATENCY + 1);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t                  state_reg, state_next;
    logic [CNT_W-1:0]        cnt_reg, cnt_next;
    logic [PTR_W-1:0]        rr_reg, rr_next;

    logic [NREQ-1:0]         grant;
    logic [PTR_W-1:0]        grant_id;
    logic                    grant_any;
    logic [WIDTH-1:0]        sel_in1, sel_in2;

    logic [LATENCY-1:0]              tag_valid_reg, tag_valid_next;
    logic [LATENCY-1:0][PTR_W-1:0]   tag_id_reg, tag_id_next;

    logic                    resp_fire;
    logic [NREQ-1:0]         resp_valid_next;

    logic                    mult_start_reg;
    logic [WIDTH-1:0]        mult_in1_reg, mult_in2_reg;
    logic [NREQ-1:0]         resp_valid_reg;
    logic [2*WIDTH-1:0]      resp_data_reg;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= RUN;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // FLUSH lasts exactly LATENCY cycles after the last flush pulse, long
    // enough for anything already inside the multiplier to fall out.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        unique case (state_reg)
            RUN: begin
                if (flush) begin
                    state_next = FLUSH;
                    cnt_next   = CNT_W'(LATENCY - 1);
                end
            end
            FLUSH: begin
                if (flush) begin
                    cnt_next = CNT_W'(LATENCY - 1);
                end else if (cnt_reg == '0) begin
                    state_next = RUN;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            default: state_next = RUN;
        endcase
    end

    // ---------------- Round-robin arbiter ----------------
    // Scan from rr_reg upward (wrapping); a flush in the same cycle wins.
    always_comb begin
        int idx;
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        idx       = 0;
        if (state_reg == RUN && !flush) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (int'(rr_reg) + k) % NREQ;
                if (!grant_any && req_valid[idx]) begin
                    grant[idx] = 1'b1;
                    grant_id   = PTR_W'(idx);
                    grant_any  = 1'b1;
                end
            end
        end
    end

    assign req_ready = grant;
    assign rr_next   = !grant_any                      ? rr_reg :
                       (grant_id == PTR_W'(NREQ - 1))  ? '0     :
                                                         grant_id + 1'b1;

    // Operand mux driven by the one-hot grant.
    always_comb begin
        sel_in1 = '0;
        sel_in2 = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant[k]) begin
                sel_in1 = req_in1[k*WIDTH +: WIDTH];
                sel_in2 = req_in2[k*WIDTH +: WIDTH];
            end
        end
    end

    // ---------------- Tag pipe ----------------
    // Stage 0 is loaded by the transfer; a flush wipes every valid bit.
    assign tag_valid_next[0] = grant_any && !flush;
    assign tag_id_next[0]    = grant_id;

    generate
        for (genvar gi = 1; gi < LATENCY; gi++) begin : g_tag
            assign tag_valid_next[gi] = tag_valid_reg[gi-1] && !flush;
            assign tag_id_next[gi]    = tag_id_reg[gi-1];
        end
    endgenerate

    // A tag leaving the pipe in a flush cycle is also dropped.
    assign resp_fire = tag_valid_reg[LATENCY-1] && !flush;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_resp
            assign resp_valid_next[gi] = resp_fire &&
                                         (tag_id_reg[LATENCY-1] == PTR_W'(gi));
        end
    endgenerate

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_reg         <= '0;
            tag_valid_reg  <= '0;
            tag_id_reg     <= '0;
            mult_start_reg <= 1'b0;
            mult_in1_reg   <= '0;
            mult_in2_reg   <= '0;
            resp_valid_reg <= '0;
            resp_data_reg  <= '0;
        end else begin
            rr_reg         <= rr_next;
            tag_valid_reg  <= tag_valid_next;
            tag_id_reg     <= tag_id_next;
            mult_start_reg <= grant_any;
            if (grant_any) begin
                mult_in1_reg <= sel_in1;
                mult_in2_reg <= sel_in2;
            end
            resp_valid_reg <= resp_valid_next;
            if (resp_fire) begin
                resp_data_reg <= mult_out;
            end
        end
    end

    assign mult_start = mult_start_reg;
    assign mult_in1   = mult_in1_reg;
    assign mult_in2   = mult_in2_reg;
    assign resp_valid = resp_valid_reg;
    assign resp_data  = resp_data_reg;
    assign busy       = (|tag_valid_reg) || (state_reg != RUN);

`ifdef UMULT_SCHED_PERF_EN
    logic [31:0] perf_issued_reg, perf_stall_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issued_reg <= '0;
            perf_stall_reg  <= '0;
        end else begin
            perf_issued_reg <= perf_issued_reg + 32'(grant_any);
            perf_stall_reg  <= perf_stall_reg + 32'((|req_valid) && !grant_any);
        end
    end

    assign perf_issued = perf_issued_reg;
    assign perf_stall  = perf_stall_reg;
`endif

endmodule

// File: tb/tb_umult_sched.sv
// -----------------------------------------------------------------------------
// tb_umult_sched
//   Bench for umult_sched (NREQ=2, LATENCY=4, WIDTH=32). A behavioural
//   multiplier model feeds mult_out. Each vector row carries the requester
//   inputs plus the expected req_ready; granted products go into a queue
//   with their due cycle and are compared when the response cycle arrives.
// -----------------------------------------------------------------------------
module tb_umult_sched;

    localparam int NREQ = 2;
    localparam int LAT  = 4;
    localparam int W    = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_in1, req_in2;
    logic [NREQ-1:0]   req_ready;
    logic              flush;
    logic              mult_start;
    logic [W-1:0]      mult_in1, mult_in2;
    logic [2*W-1:0]    mult_out;
    logic [NREQ-1:0]   resp_valid;
    logic [2*W-1:0]    resp_data;
    logic              busy;
`ifdef UMULT_SCHED_PERF_EN
    logic [31:0]       perf_issued, perf_stall;
`endif

    umult_sched #(.NREQ(NREQ), .LATENCY(LAT), .WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_in1    (req_in1),
        .req_in2    (req_in2),
        .req_ready  (req_ready),
        .flush      (flush),
        .mult_start (mult_start),
        .mult_in1   (mult_in1),
        .mult_in2   (mult_in2),
        .mult_out   (mult_out),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .busy       (busy)
`ifdef UMULT_SCHED_PERF_EN
        ,
        .perf_issued(perf_issued),
        .perf_stall (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    // Multiplier model: product valid LATENCY cycles after the transfer cycle,
    // i.e. LAT-1 register stages behind the registered operands.
    logic [2*W-1:0] mpipe [LAT-1];
    always @(posedge clk) begin
        mpipe[0] <= 64'(mult_in1) * 64'(mult_in2);
        for (int s = 1; s < LAT - 1; s++) mpipe[s] <= mpipe[s-1];
    end
    assign mult_out = mpipe[LAT-2];

    typedef struct {
        logic [1:0]  valid;
        logic [31:0] a0, b0, a1, b1;
        logic        fl;
        logic [1:0]  exp_ready;
    } vec_t;

    typedef struct {
        logic [1:0]  id_oh;
        logic [63:0] prod;
        int          due;
    } exp_t;

    vec_t  tbl[$];
    exp_t  sb[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    logic        prev_start = 1'b0;
    logic [31:0] prev_a = '0, prev_b = '0;

    function automatic vec_t mk(logic [1:0] v, logic [31:0] a0, logic [31:0] b0,
                                logic [31:0] a1, logic [31:0] b1, logic fl,
                                logic [1:0] er);
        vec_t r;
        r.valid = v; r.a0 = a0; r.b0 = b0; r.a1 = a1; r.b1 = b1;
        r.fl = fl;   r.exp_ready = er;
        return r;
    endfunction

    function automatic vec_t idle();
        return mk(2'b00, 0, 0, 0, 0, 1'b0, 2'b00);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: drive row, check at negedge, advance past posedge.
    task automatic step(input vec_t v);
        exp_t e;
        req_valid = v.valid;
        req_in1   = {v.a1, v.a0};
        req_in2   = {v.b1, v.b0};
        flush     = v.fl;
        @(negedge clk);
        check("req_ready", 64'(req_ready), 64'(v.exp_ready));
        check("mult_start", 64'(mult_start), 64'(prev_start));
        if (prev_start) begin
            check("mult_in1", 64'(mult_in1), 64'(prev_a));
            check("mult_in2", 64'(mult_in2), 64'(prev_b));
        end
        if (v.fl) sb.delete();
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            check("resp_valid", 64'(resp_valid), 64'(e.id_oh));
            check("resp_data", resp_data, e.prod);
            $display("cyc=%0d resp id=%b data=%h", cyc, resp_valid, resp_data);
        end else begin
            check("resp_valid_idle", 64'(resp_valid), 64'd0);
        end
        prev_start = |v.exp_ready;
        if (v.exp_ready[0]) begin
            e.id_oh = 2'b01; e.prod = 64'(v.a0) * 64'(v.b0); e.due = cyc + LAT + 1;
            sb.push_back(e); prev_a = v.a0; prev_b = v.b0;
        end else if (v.exp_ready[1]) begin
            e.id_oh = 2'b10; e.prod = 64'(v.a1) * 64'(v.b1); e.due = cyc + LAT + 1;
            sb.push_back(e); prev_a = v.a1; prev_b = v.b1;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_table();
        foreach (tbl[i]) step(tbl[i]);
        tbl.delete();
    endtask

    task automatic idles(input int n);
        for (int i = 0; i < n; i++) step(idle());
    endtask

    initial begin
        rst_n = 1'b0; req_valid = '0; req_in1 = '0; req_in2 = '0; flush = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_data", resp_data, 64'd0);
        check("rst_mult_start", 64'(mult_start), 64'd0);
        check("rst_mult_in1", 64'(mult_in1), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single op 3*5 on requester 0 (pointer then 1).
        tbl.push_back(mk(2'b01, 3, 5, 0, 0, 1'b0, 2'b01));
        for (int i = 0; i < 6; i++) tbl.push_back(idle());
        // Requester 1 alone, pointer back to 0.
        tbl.push_back(mk(2'b10, 0, 0, 7, 9, 1'b0, 2'b10));
        // Both valid for 6 cycles: grants alternate 0,1,0,1,0,1.
        for (int k = 0; k < 6; k++)
            tbl.push_back(mk(2'b11, 32'(10 + k), 32'(7 * k + 1), 32'(1000 + k),
                             32'(33 + k), 1'b0, (k % 2 == 0) ? 2'b01 : 2'b10));
        for (int i = 0; i < 6; i++) tbl.push_back(idle());
        // Maximum operands.
        tbl.push_back(mk(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1'b0, 2'b01));
        for (int i = 0; i < 6; i++) tbl.push_back(idle());
        run_table();
        check("busy_idle", 64'(busy), 64'd0);

        // Two ops, flush two cycles later; both results must vanish.
        tbl.push_back(mk(2'b01, 11, 12, 0, 0, 1'b0, 2'b01));
        tbl.push_back(mk(2'b10, 0, 0, 13, 14, 1'b0, 2'b10));
        tbl.push_back(idle());
        tbl.push_back(mk(2'b11, 1, 2, 3, 4, 1'b1, 2'b00));
        for (int i = 0; i < LAT; i++) tbl.push_back(mk(2'b11, 1, 2, 3, 4, 1'b0, 2'b00));
        tbl.push_back(mk(2'b11, 21, 22, 23, 24, 1'b0, 2'b01));
        run_table();
        idles(7);

        // Reset while three ops are in flight.
        tbl.push_back(mk(2'b01, 5, 6, 0, 0, 1'b0, 2'b01));
        tbl.push_back(mk(2'b10, 0, 0, 7, 8, 1'b0, 2'b10));
        tbl.push_back(mk(2'b01, 9, 10, 0, 0, 1'b0, 2'b01));
        run_table();
        req_valid = '0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_resp_valid", 64'(resp_valid), 64'd0);
        check("arst_resp_data", resp_data, 64'd0);
        check("arst_mult_start", 64'(mult_start), 64'd0);
        check("arst_mult_in1", 64'(mult_in1), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        sb.delete();
        prev_start = 1'b0;
        @(posedge clk); #1; cyc++;
        idles(2);
        rst_n = 1'b1;
        idles(8);
        // Pointer back at 0: requester 0 wins even though 1 is also waiting.
        step(mk(2'b11, 2, 3, 4, 5, 1'b0, 2'b01));
        idles(7);

`ifdef UMULT_SCHED_PERF_EN
        rst_n = 1'b0;
        sb.delete(); prev_start = 1'b0;
        @(posedge clk); #1; cyc++;
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++)
            step(mk(2'b11, 32'(k), 3, 32'(k), 5, 1'b0, (k % 2 == 0) ? 2'b01 : 2'b10));
        check("perf_issued", 64'(perf_issued), 64'd10);
        check("perf_stall", 64'(perf_stall), 64'd0);
        idles(7);
`endif

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
